// File: rtl/program_memory_mp_if.sv
// Signal bundle for program_memory_mp: byte-stream image loader, load status and the multi-port read side.
interface program_memory_mp_if #(
  parameter int NUM_PORTS   = 2,
  parameter int WORD_BYTES  = 4,
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = 32
);
  localparam int WL_W   = $clog2(DEPTH_WORDS) + 1;
  localparam int DATA_W = WORD_BYTES * 8;

  // Handshake: load bytes have no backpressure (a byte is taken on every cycle load_valid_in is high
  // while loading); a read request is accepted exactly when rd_req_in[p] and ready_out are high in the
  // same cycle, and rd_valid_out[p] is a single-cycle qualifier for rd_data_out/rd_oob_out of port p.
  logic                        load_valid_in;
  logic [7:0]                  load_byte_in;
  logic                        load_last_in;
  logic                        reload_in;
  logic                        ready_out;
  logic                        sys_rst_out;
  logic                        overflow_out;
  logic [WL_W-1:0]             words_loaded_out;
  logic [1:0]                  state_dbg_out;
  logic [NUM_PORTS-1:0]        rd_req_in;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr_in;
  logic [NUM_PORTS*DATA_W-1:0] rd_data_out;
  logic [NUM_PORTS-1:0]        rd_valid_out;
  logic [NUM_PORTS-1:0]        rd_oob_out;

  modport master (
    output load_valid_in, load_byte_in, load_last_in, reload_in, rd_req_in, rd_addr_in,
    input  ready_out, sys_rst_out, overflow_out, words_loaded_out, state_dbg_out,
           rd_data_out, rd_valid_out, rd_oob_out
  );

  modport slave (
    input  load_valid_in, load_byte_in, load_last_in, reload_in, rd_req_in, rd_addr_in,
    output ready_out, sys_rst_out, overflow_out, words_loaded_out, state_dbg_out,
           rd_data_out, rd_valid_out, rd_oob_out
  );
endinterface

// File: rtl/program_memory_mp.sv
// Multi-port instruction memory: packs a streamed byte image into words, then serves NUM_PORTS
// independent fixed-latency read ports. Pulses sys_rst_out when a load completes.
module program_memory_mp #(
  parameter int NUM_PORTS    = 2,
  parameter int WORD_BYTES   = 4,
  parameter int DEPTH_WORDS  = 2048,
  parameter int READ_LATENCY = 2,
  parameter int BIG_ENDIAN   = 1,
  parameter int ADDR_W       = 32
) (
  input logic                clk_in,
  input logic                rst_in,
  program_memory_mp_if.slave bus
);
  localparam int DATA_W = WORD_BYTES * 8;
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int WL_W   = AW + 1;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SH     = $clog2(WORD_BYTES);
  localparam int L      = READ_LATENCY;

  typedef enum logic [1:0] {
    ST_LOADING = 2'd0,
    ST_DONE    = 2'd1,
    ST_READY   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   partial_q, partial_d;
  logic [WL_W-1:0]     words_q, words_d;
  logic                overflow_q, overflow_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   shifted;
  logic                byte_full;
  int                  pad_bits;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic                ready;
  logic [NUM_PORTS-1:0] acc;
  logic [NUM_PORTS-1:0] rd_oob;
  logic [ADDR_W-1:0]    rd_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] pv_q [L];
  logic [NUM_PORTS-1:0] pv_d [L];
  logic [NUM_PORTS-1:0] po_q [L];
  logic [NUM_PORTS-1:0] po_d [L];
  logic [DATA_W-1:0]    pd_q [NUM_PORTS][L];
  logic [DATA_W-1:0]    pd_d [NUM_PORTS][L];

  // Load FSM, byte packing and the registered write port.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    partial_d  = partial_q;
    words_d    = words_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    shifted    = '0;
    byte_full  = 1'b0;
    pad_bits   = 0;
    unique case (state_q)
      ST_LOADING: begin
        if (bus.load_valid_in) begin
          if (BIG_ENDIAN != 0) shifted = (partial_q << 8) | DATA_W'(bus.load_byte_in);
          else                 shifted = (partial_q >> 8) | (DATA_W'(bus.load_byte_in) << (DATA_W - 8));
          byte_full = (byte_cnt_q == BC_W'(WORD_BYTES - 1));
          if (byte_full || bus.load_last_in) begin
            // Slide the filled lanes into place so untouched lanes read as zero.
            pad_bits = (WORD_BYTES - 1 - int'(byte_cnt_q)) * 8;
            if (BIG_ENDIAN != 0) wr_data_d = shifted << pad_bits;
            else                 wr_data_d = shifted >> pad_bits;
            partial_d  = '0;
            byte_cnt_d = '0;
            if (words_q == WL_W'(DEPTH_WORDS)) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d  = 1'b1;
              wr_idx_d = words_q[AW-1:0];
              words_d  = words_q + 1'b1;
            end
          end else begin
            partial_d  = shifted;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (bus.load_last_in) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_READY;
      ST_READY: begin
        if (bus.reload_in) begin
          state_d    = ST_LOADING;
          byte_cnt_d = '0;
          partial_d  = '0;
          words_d    = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = ST_LOADING;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_LOADING;
      byte_cnt_q <= '0;
      partial_q  <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      partial_q  <= partial_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Contents survive reset; only the pending write is dropped.
  always_ff @(posedge clk_in) begin
    if (wr_en_q) mem[wr_idx_q] <= wr_data_q;
  end

  assign ready                = (state_q == ST_READY);
  assign bus.ready_out        = ready;
  assign bus.sys_rst_out      = (state_q == ST_DONE);
  assign bus.overflow_out     = overflow_q;
  assign bus.words_loaded_out = words_q;
  assign bus.state_dbg_out    = state_q;

  // Read pipeline: stage 0 captures the array word, the final stage holds data between valids.
  always_comb begin
    acc    = '0;
    rd_oob = '0;
    for (int s = 0; s < L; s++) begin
      pv_d[s] = '0;
      po_d[s] = '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int s = 0; s < L; s++) pd_d[p][s] = pd_q[p][s];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_idx[p]  = bus.rd_addr_in[p*ADDR_W +: ADDR_W] >> SH;
      rd_oob[p]  = (rd_idx[p] >= ADDR_W'(DEPTH_WORDS));
      acc[p]     = bus.rd_req_in[p] & ready;
      pd_d[p][0] = rd_oob[p] ? '0 : mem[rd_idx[p][AW-1:0]];
    end
    pv_d[0] = acc;
    po_d[0] = acc & rd_oob;
    for (int s = 1; s < L; s++) begin
      pv_d[s] = pv_q[s-1];
      po_d[s] = po_q[s-1];
      for (int p = 0; p < NUM_PORTS; p++) pd_d[p][s] = pd_q[p][s-1];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!pv_d[L-1][p]) pd_d[p][L-1] = pd_q[p][L-1];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < L; s++) begin
        pv_q[s] <= '0;
        po_q[s] <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int s = 0; s < L; s++) pd_q[p][s] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      po_q <= po_d;
      pd_q <= pd_d;
    end
  end

  always_comb begin
    bus.rd_data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) bus.rd_data_out[p*DATA_W +: DATA_W] = pd_q[p][L-1];
  end

  assign bus.rd_valid_out = pv_q[L-1];
  assign bus.rd_oob_out   = po_q[L-1];
endmodule

// File: tb/tb_program_memory_mp.sv
// Bench for program_memory_mp: a default big-endian instance (A) and a small little-endian,
// 4-word, latency-3 instance (B), checked against an image-level reference model.
module tb_program_memory_mp;
  localparam int LAT_A = 2, LAT_B = 3, DEPTH_A = 2048, DEPTH_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_memory_mp_if #(.NUM_PORTS(2), .WORD_BYTES(4), .DEPTH_WORDS(DEPTH_A), .ADDR_W(32)) ifa ();
  program_memory_mp_if #(.NUM_PORTS(1), .WORD_BYTES(4), .DEPTH_WORDS(DEPTH_B), .ADDR_W(32)) ifb ();

  program_memory_mp #(.NUM_PORTS(2), .WORD_BYTES(4), .DEPTH_WORDS(DEPTH_A), .READ_LATENCY(LAT_A),
                      .BIG_ENDIAN(1), .ADDR_W(32))
    dut_a (.clk_in(clk), .rst_in(rst), .bus(ifa));
  program_memory_mp #(.NUM_PORTS(1), .WORD_BYTES(4), .DEPTH_WORDS(DEPTH_B), .READ_LATENCY(LAT_B),
                      .BIG_ENDIAN(0), .ADDR_W(32))
    dut_b (.clk_in(clk), .rst_in(rst), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word arrays built from the image bytes, plus scoreboards {due_cycle, oob, data}.
  logic [31:0] ma_mem [DEPTH_A];
  logic [31:0] mb_mem [DEPTH_B];
  int          ma_words = 0, mb_words = 0;
  bit          a_rdy_m = 1'b0, b_rdy_m = 1'b0;
  logic [7:0]  img_q [$];
  logic [63:0] exp_q [3][$];
  logic [31:0] last_d [3];
  int          pulses_a = 0, pulses_b = 0, exp_pulses_a = 0, exp_pulses_b = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] img_word(input int i, input bit be);
    logic [31:0] w;
    logic [7:0]  by;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      by = (i*4 + b < img_q.size()) ? img_q[i*4 + b] : 8'h00;
      if (be) w[(3-b)*8 +: 8] = by;
      else    w[b*8 +: 8]     = by;
    end
    return w;
  endfunction

  task automatic mon(input int k, input bit v, input bit o, input logic [31:0] d);
    logic [63:0] e;
    if (v) begin
      if (exp_q[k].size() == 0) begin
        check_eq("unexpected_valid", 64'(v), 64'd0);
      end else begin
        e = exp_q[k].pop_front();
        check_eq("rd_cycle", 64'(cyc), 64'(e[63:33]));
        check_eq("rd_data", 64'(d), 64'(e[31:0]));
        check_eq("rd_oob", 64'(o), 64'(e[32]));
        last_d[k] = e[31:0];
      end
    end else begin
      check_eq("rd_data_hold", 64'(d), 64'(last_d[k]));
      if (exp_q[k].size() > 0 && int'(exp_q[k][0][63:33]) < cyc) begin
        check_eq("rd_missing", 64'(v), 64'd1);
        void'(exp_q[k].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.rd_valid_out[0], ifa.rd_oob_out[0], ifa.rd_data_out[31:0]);
      mon(1, ifa.rd_valid_out[1], ifa.rd_oob_out[1], ifa.rd_data_out[63:32]);
      mon(2, ifb.rd_valid_out[0], ifb.rd_oob_out[0], ifb.rd_data_out[31:0]);
      if (ifa.sys_rst_out) pulses_a <= pulses_a + 1;
      if (ifb.sys_rst_out) pulses_b <= pulses_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_reqs();
    ifa.rd_req_in = '0;
    ifb.rd_req_in = '0;
  endtask

  // Drives one request for this cycle; an expectation is recorded only if the model says ready.
  task automatic req_exp(input int k, input logic [31:0] addr, input logic [31:0] d, input bit o);
    if (k == 2) begin
      ifb.rd_req_in[0] = 1'b1;
      ifb.rd_addr_in   = addr;
      if (b_rdy_m) exp_q[2].push_back({31'(cyc + LAT_B), o, d});
    end else begin
      ifa.rd_req_in[k]            = 1'b1;
      ifa.rd_addr_in[k*32 +: 32]  = addr;
      if (a_rdy_m) exp_q[k].push_back({31'(cyc + LAT_A), o, d});
    end
  endtask

  task automatic req_model(input int k, input logic [31:0] addr);
    logic [31:0] idx;
    int          depth;
    idx   = addr >> 2;
    depth = (k == 2) ? DEPTH_B : DEPTH_A;
    if (idx >= 32'(depth)) req_exp(k, addr, 32'd0, 1'b1);
    else req_exp(k, addr, (k == 2) ? mb_mem[idx] : ma_mem[idx], 1'b0);
  endtask

  function automatic logic [31:0] rand_addr_a();
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h2000 + $urandom_range(0, 32'h7fff_0000);
    return (32'($urandom_range(0, ma_words - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic load_image(input bit to_b, input bit with_last, input bit gaps);
    for (int i = 0; i < img_q.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          ifa.load_valid_in = 1'b0;
          ifb.load_valid_in = 1'b0;
          tick();
        end
      end
      if (to_b) begin
        ifb.load_valid_in = 1'b1;
        ifb.load_byte_in  = img_q[i];
        ifb.load_last_in  = with_last && (i == img_q.size() - 1);
      end else begin
        ifa.load_valid_in = 1'b1;
        ifa.load_byte_in  = img_q[i];
        ifa.load_last_in  = with_last && (i == img_q.size() - 1);
      end
      tick();
    end
    ifa.load_valid_in = 1'b0;
    ifa.load_last_in  = 1'b0;
    ifb.load_valid_in = 1'b0;
    ifb.load_last_in  = 1'b0;
  endtask

  // Called right after the last byte was taken: checks the DONE pulse, then READY status.
  task automatic finish_load(input bit to_b);
    int nw, depth, words;
    bit ovf;
    depth = to_b ? DEPTH_B : DEPTH_A;
    nw    = (img_q.size() + 3) / 4;
    words = (nw > depth) ? depth : nw;
    ovf   = (nw > depth);
    for (int i = 0; i < words; i++) begin
      if (to_b) mb_mem[i] = img_word(i, 1'b0);
      else      ma_mem[i] = img_word(i, 1'b1);
    end
    @(negedge clk);
    if (to_b) begin
      check_eq("b_sys_rst_pulse", 64'(ifb.sys_rst_out), 64'd1);
      check_eq("b_ready_in_done", 64'(ifb.ready_out), 64'd0);
    end else begin
      check_eq("a_sys_rst_pulse", 64'(ifa.sys_rst_out), 64'd1);
      check_eq("a_ready_in_done", 64'(ifa.ready_out), 64'd0);
    end
    @(negedge clk);
    if (to_b) begin
      check_eq("b_sys_rst_end", 64'(ifb.sys_rst_out), 64'd0);
      check_eq("b_ready", 64'(ifb.ready_out), 64'd1);
      check_eq("b_words_loaded", 64'(ifb.words_loaded_out), 64'(words));
      check_eq("b_overflow", 64'(ifb.overflow_out), 64'(ovf));
      mb_words = words;
      b_rdy_m  = 1'b1;
      exp_pulses_b++;
    end else begin
      check_eq("a_sys_rst_end", 64'(ifa.sys_rst_out), 64'd0);
      check_eq("a_ready", 64'(ifa.ready_out), 64'd1);
      check_eq("a_words_loaded", 64'(ifa.words_loaded_out), 64'(words));
      check_eq("a_overflow", 64'(ifa.overflow_out), 64'(ovf));
      ma_words = words;
      a_rdy_m  = 1'b1;
      exp_pulses_a++;
    end
    tick();
  endtask

  task automatic reload(input bit to_b);
    if (to_b) begin ifb.reload_in = 1'b1; b_rdy_m = 1'b0; end
    else      begin ifa.reload_in = 1'b1; a_rdy_m = 1'b0; end
    tick();
    ifa.reload_in = 1'b0;
    ifb.reload_in = 1'b0;
    @(negedge clk);
    if (to_b) begin
      check_eq("b_reload_ready", 64'(ifb.ready_out), 64'd0);
      check_eq("b_reload_words", 64'(ifb.words_loaded_out), 64'd0);
      check_eq("b_reload_ovf", 64'(ifb.overflow_out), 64'd0);
    end else begin
      check_eq("a_reload_ready", 64'(ifa.ready_out), 64'd0);
      check_eq("a_reload_words", 64'(ifa.words_loaded_out), 64'd0);
    end
    tick();
  endtask

  task automatic drain_check();
    clear_reqs();
    wait_cycles(LAT_B + 2);
    check_eq("a0_drained", 64'(exp_q[0].size()), 64'd0);
    check_eq("a1_drained", 64'(exp_q[1].size()), 64'd0);
    check_eq("b_drained", 64'(exp_q[2].size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string who);
    check_eq({who, "_a_ready"}, 64'(ifa.ready_out), 64'd0);
    check_eq({who, "_a_sys_rst"}, 64'(ifa.sys_rst_out), 64'd0);
    check_eq({who, "_a_ovf"}, 64'(ifa.overflow_out), 64'd0);
    check_eq({who, "_a_words"}, 64'(ifa.words_loaded_out), 64'd0);
    check_eq({who, "_a_valid"}, 64'(ifa.rd_valid_out), 64'd0);
    check_eq({who, "_a_oob"}, 64'(ifa.rd_oob_out), 64'd0);
    check_eq({who, "_a_data"}, 64'(ifa.rd_data_out), 64'd0);
    check_eq({who, "_b_ready"}, 64'(ifb.ready_out), 64'd0);
    check_eq({who, "_b_ovf"}, 64'(ifb.overflow_out), 64'd0);
    check_eq({who, "_b_words"}, 64'(ifb.words_loaded_out), 64'd0);
    check_eq({who, "_b_data"}, 64'(ifb.rd_data_out), 64'd0);
  endtask

  initial begin
    ifa.load_valid_in = 1'b0; ifa.load_byte_in = '0; ifa.load_last_in = 1'b0; ifa.reload_in = 1'b0;
    ifa.rd_req_in = '0; ifa.rd_addr_in = '0;
    ifb.load_valid_in = 1'b0; ifb.load_byte_in = '0; ifb.load_last_in = 1'b0; ifb.reload_in = 1'b0;
    ifb.rd_req_in = '0; ifb.rd_addr_in = '0;
    for (int k = 0; k < 3; k++) last_d[k] = '0;

    // Reset values.
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Big-endian packing on A.
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load_image(1'b0, 1'b1, 1'b0);
    finish_load(1'b0);
    req_exp(0, 32'h0, 32'h0102_0304, 1'b0);
    req_exp(1, 32'h5, 32'h0506_0708, 1'b0);
    tick();
    drain_check();

    // Little-endian packing on B, low address bits ignored, out-of-range index.
    load_image(1'b1, 1'b1, 1'b1);
    finish_load(1'b1);
    req_exp(2, 32'h4, 32'h0807_0605, 1'b0); tick(); clear_reqs();
    req_exp(2, 32'h6, 32'h0807_0605, 1'b0); tick(); clear_reqs();
    req_exp(2, 32'h0, 32'h0403_0201, 1'b0); tick(); clear_reqs();
    req_exp(2, 32'h10, 32'h0, 1'b1);        tick();
    drain_check();

    // Reload A with a partial final word; requests during loading must be dropped.
    reload(1'b0);
    for (int i = 0; i < 3; i++) begin
      clear_reqs();
      req_exp(0, 32'h0, 32'h0, 1'b0);
      req_exp(1, 32'h4, 32'h0, 1'b0);
      tick();
    end
    clear_reqs();
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_image(1'b0, 1'b1, 1'b1);
    finish_load(1'b0);
    req_exp(0, 32'h0, 32'hAABB_CCDD, 1'b0);
    req_exp(1, 32'h7, 32'hEE00_0000, 1'b0);
    tick(); clear_reqs();
    req_exp(0, 32'h4, 32'hEE00_0000, 1'b0);
    tick();
    drain_check();

    // Both ports back-to-back for 16 cycles, one fixed out-of-range probe.
    for (int c = 0; c < 16; c++) begin
      clear_reqs();
      if (c == 5) req_exp(1, 32'h2000, 32'h0, 1'b1);
      else        req_model(1, rand_addr_a());
      req_model(0, rand_addr_a());
      tick();
    end
    drain_check();

    // Random images and random read traffic on A.
    for (int it = 0; it < 3; it++) begin
      reload(1'b0);
      img_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 48)); i++) img_q.push_back(8'($urandom_range(0, 255)));
      load_image(1'b0, 1'b1, 1'b1);
      finish_load(1'b0);
      for (int c = 0; c < 20; c++) begin
        clear_reqs();
        if ($urandom_range(0, 3) != 0) req_model(0, rand_addr_a());
        if ($urandom_range(0, 3) != 0) req_model(1, rand_addr_a());
        tick();
      end
      drain_check();
    end

    // Overflow on B: 20 bytes into 4 words.
    reload(1'b1);
    img_q.delete();
    for (int i = 0; i < 20; i++) img_q.push_back(8'($urandom_range(0, 255)));
    load_image(1'b1, 1'b1, 1'b0);
    finish_load(1'b1);
    for (int w = 0; w < 4; w++) begin
      clear_reqs();
      req_model(2, 32'(w * 4));
      tick();
    end
    clear_reqs();
    req_exp(2, 32'h10, 32'h0, 1'b1);
    tick();
    drain_check();
    check_eq("a_sys_rst_count", 64'(pulses_a), 64'(exp_pulses_a));
    check_eq("b_sys_rst_count", 64'(pulses_b), 64'(exp_pulses_b));

    // Asynchronous reset in the middle of an overflowing load on B.
    reload(1'b1);
    img_q.delete();
    for (int i = 0; i < 22; i++) img_q.push_back(8'($urandom_range(0, 255)));
    load_image(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("b_midload_ovf", 64'(ifb.overflow_out), 64'd1);
    check_eq("b_midload_words", 64'(ifb.words_loaded_out), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      last_d[k] = '0;
    end
    a_rdy_m = 1'b0;
    b_rdy_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // A recovers from reset straight into LOADING.
    img_q = '{8'h11, 8'h22, 8'h33};
    load_image(1'b0, 1'b1, 1'b0);
    finish_load(1'b0);
    req_exp(0, 32'h1, 32'h1122_3300, 1'b0);
    tick();
    drain_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_memory_mp.md
Name: program_memory_mp

Overview:
- Parametrised multi-port instruction memory.
- Loads an image from a byte stream, packs bytes into words of configurable width and endianness, and writes them sequentially from word 0.
- After loading, serves NUM_PORTS independent read ports (fetch, data-side instruction reads, debug) with fixed, configurable latency.
- Pulses a system reset when the load completes, and supports reloading at runtime without a global reset.

Parameters:
- NUM_PORTS, 2, number of independent read ports (1..4).
- WORD_BYTES, 4, bytes per stored word; must be a power of two (1, 2, 4, 8).
- DEPTH_WORDS, 2048, number of stored words.
- READ_LATENCY, 2, cycles from accepted rd_req to rd_valid (1..4).
- BIG_ENDIAN, 1, byte order of the packed word: 1 = first streamed byte in the MSBs, 0 = first byte in the LSBs.
- ADDR_W, 32, byte-address width of the read ports.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- load_valid_in  in  1  load_byte_in is valid this cycle.
- load_byte_in  in  8  image byte.
- load_last_in  in  1  marks the final byte of the image; qualified by load_valid_in.
- reload_in  in  1  single-cycle pulse; restarts loading from word 0 (honoured only in READY).
- ready_out  out  1  memory is serving reads.
- sys_rst_out  out  1  one-cycle pulse when a load completes.
- overflow_out  out  1  sticky; image exceeded DEPTH_WORDS.
- words_loaded_out  out  $clog2(DEPTH_WORDS)+1  number of words written by the last or current load.
- rd_req_in  in  NUM_PORTS  per-port read request.
- rd_addr_in  in  NUM_PORTS*ADDR_W  per-port byte address; port p occupies slice [p*ADDR_W +: ADDR_W].
- rd_data_out  out  NUM_PORTS*WORD_BYTES*8  per-port read data.
- rd_valid_out  out  NUM_PORTS  per-port data valid.
- rd_oob_out  out  NUM_PORTS  per-port flag: the returned read was out of range; aligned with rd_valid_out.

Behaviour:
- Reset (async assert, sync release):
  - State = LOADING; ready_out=0, sys_rst_out=0, overflow_out=0, words_loaded_out=0.
  - All rd_valid_out=0, rd_oob_out=0, rd_data_out=0.
  - Byte counter=0, partial-word register=0.
  - Memory contents are not reset.
- State LOADING:
  - Each load_valid_in byte shifts into the partial word.
    - BIG_ENDIAN=1: shift in at the LSB, so byte 0 ends up in the MSBs.
    - BIG_ENDIAN=0: shift in at the MSB, so byte 0 ends up in the LSBs.
  - When the byte counter wraps at WORD_BYTES, the word is written at index words_loaded_out, then words_loaded_out increments.
  - The write occurs the cycle after the last byte of the word is accepted.
  - Words beyond DEPTH_WORDS are not written. overflow_out is set; words_loaded_out saturates at DEPTH_WORDS.
  - On load_last_in with a partial word pending:
    - Unfilled byte lanes are zero-padded and the word is written.
    - Then go to DONE.
- State DONE (1 cycle): sys_rst_out=1; next state READY.
- State READY:
  - ready_out=1.
  - load_valid_in is ignored.
  - reload_in → LOADING; counters and overflow_out are cleared, and ready_out drops the next cycle.
- Reads:
  - A request is accepted only when ready_out=1 in the same cycle. Requests while not ready are dropped, with no valid returned.
  - Word index = rd_addr >> log2(WORD_BYTES); low address bits are ignored.
  - Accepted request at cycle t → rd_valid_out[p]=1 at t+READ_LATENCY, with data for that index. Ports are fully pipelined (one request per cycle per port) and independent; no arbitration or stalls.
  - Index ≥ DEPTH_WORDS: data=0, rd_oob_out[p]=1 alongside valid.
  - rd_data_out holds its last value when valid is low.
- Reload mid-flight: reads accepted before ready_out fell still complete with valid, and may return old or new data for words being overwritten.
- reload_in while LOADING/DONE: ignored.
- Simultaneous load_valid_in with load_last_in on a word boundary: the final word is written without padding; DONE follows.

Test Plan:
- Defaults; stream bytes 01,02,03,04,05,06,07,08 (last on 08) → sys_rst_out pulses once; words_loaded_out=2; read port0 addr 0x0 → at t+2 data=0x01020304, rd_valid=1, rd_oob=0.
- BIG_ENDIAN=0, same stream → addr 0x4 returns 0x08070605; addr 0x6 returns the same word.
- Partial word: stream 0xAA,0xBB,0xCC,0xDD,0xEE (last) → word1=0xEE000000 (BE), words_loaded_out=2.
- Both ports request every cycle with distinct addresses for 16 cycles → 16 valids per port, in order, each exactly 2 cycles after its request; addr 0x2000 (index 2048) → data 0, rd_oob=1.
- DEPTH_WORDS=4, stream 20 bytes → overflow_out=1; words_loaded_out=4; words 0..3 intact.
- reload_in in READY, then requests during reload → no rd_valid for those requests; new image readable after the second sys_rst_out; rst_in asserted mid-load → all outputs go to reset values immediately (asynchronously).
